// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared helpers for the bus round-robin arbiter
package bus_arb_pkg;

    // Index width that is never zero, so a 1-entry structure still gets a 1-bit pointer.
    function automatic int idx_width(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Successor of an index in a ring of n entries.
    function automatic int rr_next(input int sel, input int n);
        return (sel >= n - 1) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/bus_arb_tag_fifo.sv
// rtl/bus_arb_tag_fifo.sv - in-order queue of granted host indices awaiting a response
module bus_arb_tag_fifo
    import bus_arb_pkg::*;
#(
    parameter int Width = 2,
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int PtrW = idx_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = PtrW'(rr_next(int'(wr_ptr_q), Depth));
        end
        if (pop_ok) begin
            rd_ptr_d = PtrW'(rr_next(int'(rd_ptr_q), Depth));
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - req/gnt/rvalid arbiter sharing one device port among several hosts
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 3,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2,
    parameter bit FixedPriority  = 1'b0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NrHosts-1:0]               host_req_i,
    output logic [NrHosts-1:0]               host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0]               host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]   host_be_i,
    input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]               host_rvalid_o,
    output logic [DataWidth-1:0]             host_rdata_o,
    output logic [NrHosts-1:0]               host_err_o,
    output logic                             dev_req_o,
    input  logic                             dev_gnt_i,
    output logic [AddressWidth-1:0]          dev_addr_o,
    output logic                             dev_we_o,
    output logic [DataWidth/8-1:0]           dev_be_o,
    output logic [DataWidth-1:0]             dev_wdata_o,
    input  logic                             dev_rvalid_i,
    input  logic [DataWidth-1:0]             dev_rdata_i,
    input  logic                             dev_err_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                             proto_err_o
);

    localparam int IdxW = idx_width(NrHosts);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int BeW  = DataWidth / 8;

    logic [IdxW-1:0] prio_q, prio_d;
    logic [IdxW-1:0] locked_sel_q, locked_sel_d;
    logic            lock_q, lock_d;
    logic            proto_err_q, proto_err_d;

    logic [IdxW-1:0] sel, scan_idx, head;
    logic            found;
    logic            any_req, full, empty, accept, pop;
    logic [CntW-1:0] count;

    logic [AddressWidth-1:0] addr_arr  [NrHosts];
    logic [BeW-1:0]          be_arr    [NrHosts];
    logic [DataWidth-1:0]    wdata_arr [NrHosts];

    for (genvar h = 0; h < NrHosts; h++) begin : g_unpack
        assign addr_arr[h]  = host_addr_i[h*AddressWidth +: AddressWidth];
        assign be_arr[h]    = host_be_i[h*BeW +: BeW];
        assign wdata_arr[h] = host_wdata_i[h*DataWidth +: DataWidth];
    end

    // Scan from the priority pointer with wrap; a stalled selection stays pinned.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        scan_idx = FixedPriority ? '0 : prio_q;
        if (lock_q) begin
            sel = locked_sel_q;
        end else begin
            for (int k = 0; k < NrHosts; k++) begin
                if (!found && host_req_i[scan_idx]) begin
                    sel   = scan_idx;
                    found = 1'b1;
                end
                scan_idx = IdxW'(rr_next(int'(scan_idx), NrHosts));
            end
        end
    end

    assign any_req   = |host_req_i;
    assign dev_req_o = (any_req | lock_q) & ~full;
    assign accept    = dev_req_o & dev_gnt_i;
    assign pop       = dev_rvalid_i & ~empty;

    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (dev_req_o) begin
            dev_addr_o  = addr_arr[sel];
            dev_we_o    = host_we_i[sel];
            dev_be_o    = be_arr[sel];
            dev_wdata_o = wdata_arr[sel];
        end
    end

    assign host_gnt_o    = accept ? (NrHosts'(1) << sel) : '0;
    assign host_rvalid_o = pop ? (NrHosts'(1) << head) : '0;
    assign host_err_o    = (pop && dev_err_i) ? (NrHosts'(1) << head) : '0;
    assign host_rdata_o  = dev_rdata_i;
    assign outstanding_o = count;
    assign proto_err_o   = proto_err_q;

    always_comb begin
        prio_d       = prio_q;
        lock_d       = lock_q;
        locked_sel_d = locked_sel_q;
        proto_err_d  = proto_err_q | (dev_rvalid_i & empty);
        if (accept) begin
            lock_d = 1'b0;
            if (!FixedPriority) begin
                prio_d = IdxW'(rr_next(int'(sel), NrHosts));
            end
        end else if (dev_req_o) begin
            lock_d       = 1'b1;
            locked_sel_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q       <= '0;
            lock_q       <= 1'b0;
            locked_sel_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            lock_q       <= lock_d;
            locked_sel_q <= locked_sel_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Push happens only on accept, which already excludes the full case.
    bus_arb_tag_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding),
        .CntW  (CntW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int OW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]      host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [N*AW-1:0]   host_addr;
    logic [N*DW/8-1:0] host_be;
    logic [N*DW-1:0]   host_wdata;
    logic [DW-1:0]     host_rdata;
    logic              dev_req, dev_gnt, dev_we, dev_rvalid, dev_err, proto_err;
    logic [AW-1:0]     dev_addr;
    logic [DW/8-1:0]   dev_be;
    logic [DW-1:0]     dev_wdata, dev_rdata;
    logic [OW-1:0]     outstanding;

    bus_rr_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW),
        .MaxOutstanding(MO), .FixedPriority(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt),
        .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
        .host_wdata_i(host_wdata), .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
        .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .outstanding_o(outstanding), .proto_err_o(proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: priority pointer, optional pinned selection, queue of granted hosts.
    int m_prio;
    bit m_locked;
    int m_lsel;
    int m_tags[$];
    bit m_proto;

    logic [N-1:0]  s_gnt, s_rvalid, s_err;
    logic          s_dreq, s_we, s_proto;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rdata;
    logic [OW-1:0] s_out;

    typedef struct {
        logic [N-1:0] req;
        bit           gnt;
        bit           rv;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        bit           e_req;
        int           e_out;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_locked = 0;
        m_lsel = 0;
        m_tags.delete();
        m_proto = 0;
    endtask

    // Inputs are already applied; sample mid-cycle, compare, then advance across the edge.
    task automatic cycle(input bit do_check);
        int sel, idx;
        bit dreq, acc, pop;
        logic [N-1:0] one, eg, ev, ee;
        logic [AW-1:0] ea;
        one = 1;
        #4;
        s_gnt = host_gnt; s_rvalid = host_rvalid; s_err = host_err;
        s_dreq = dev_req; s_we = dev_we; s_proto = proto_err;
        s_addr = dev_addr; s_rdata = host_rdata; s_out = outstanding;
        sel = 0;
        if (m_locked) begin
            sel = m_lsel;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = (m_prio + k) % N;
                if (host_req[idx]) sel = idx;
            end
        end
        dreq = ((|host_req) || m_locked) && (m_tags.size() < MO);
        acc  = dreq && dev_gnt;
        pop  = dev_rvalid && (m_tags.size() > 0);
        eg = acc ? (one << sel) : '0;
        ev = pop ? (one << m_tags[0]) : '0;
        ee = (pop && dev_err) ? (one << m_tags[0]) : '0;
        ea = dreq ? host_addr[sel*AW +: AW] : '0;
        if (do_check) begin
            chk("gnt", s_gnt, eg);
            chk("dev_req", s_dreq, dreq);
            chk("dev_addr", s_addr, ea);
            chk("dev_we", s_we, dreq ? host_we[sel] : 1'b0);
            chk("dev_wdata", dev_wdata, dreq ? host_wdata[sel*DW +: DW] : '0);
            chk("rvalid", s_rvalid, ev);
            chk("err", s_err, ee);
            chk("rdata", s_rdata, dev_rdata);
            chk("outstanding", s_out, m_tags.size());
            chk("proto_err", s_proto, m_proto);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (pop) void'(m_tags.pop_front());
            else if (dev_rvalid) m_proto = 1;
            if (acc) begin
                m_tags.push_back(sel);
                m_prio = (sel + 1) % N;
                m_locked = 0;
            end else if (dreq) begin
                m_locked = 1;
                m_lsel = sel;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input bit gnt, input bit rv);
        host_req = req;
        dev_gnt = gnt;
        dev_rvalid = rv;
        dev_rdata = $urandom;
    endtask

    task automatic do_reset();
        drive('0, 0, 0);
        rst = 1;
        cycle(0);
        rst = 0;
    endtask

    task automatic new_req(input int h);
        host_req[h] = 1'b1;
        host_addr[h*AW +: AW] = $urandom;
        host_we[h] = 1'($urandom_range(0, 1));
        host_wdata[h*DW +: DW] = $urandom;
        host_be[h*4 +: 4] = 4'($urandom);
    endtask

    initial begin
        rst = 1;
        host_req = '0; host_we = '0; host_be = '1; host_wdata = '0;
        dev_gnt = 0; dev_rvalid = 0; dev_rdata = '0; dev_err = 0;
        for (int h = 0; h < N; h++) begin
            host_addr[h*AW +: AW] = 32'h20000 + 32'(2 * h);
            host_wdata[h*DW +: DW] = 32'hA000_0000 + 32'(h);
        end
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        drive('0, 0, 0);
        cycle(1);
        chk("rst_gnt", s_gnt, '0);
        chk("rst_rvalid", s_rvalid, '0);
        chk("rst_dev_req", s_dreq, 1'b0);
        chk("rst_outstanding", s_out, '0);
        chk("rst_proto", s_proto, 1'b0);

        tbl.push_back(vec_t'{3'b111, 1, 0, 3'b001, 3'b000, 1, 0});
        tbl.push_back(vec_t'{3'b111, 1, 1, 3'b010, 3'b001, 1, 1});
        tbl.push_back(vec_t'{3'b111, 1, 1, 3'b100, 3'b010, 1, 1});
        tbl.push_back(vec_t'{3'b111, 1, 1, 3'b001, 3'b100, 1, 1});
        tbl.push_back(vec_t'{3'b111, 1, 1, 3'b010, 3'b001, 1, 1});
        tbl.push_back(vec_t'{3'b111, 1, 1, 3'b100, 3'b010, 1, 1});
        tbl.push_back(vec_t'{3'b000, 0, 1, 3'b000, 3'b100, 0, 1});
        tbl.push_back(vec_t'{3'b000, 0, 0, 3'b000, 3'b000, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].gnt, tbl[i].rv);
            cycle(1);
            chk("tbl_gnt", s_gnt, tbl[i].e_gnt);
            chk("tbl_rvalid", s_rvalid, tbl[i].e_rv);
            chk("tbl_dev_req", s_dreq, tbl[i].e_req);
            chk("tbl_outstanding", s_out, tbl[i].e_out);
        end

        // Stall lock: host 0 arrives while host 2 is stalled and must wait.
        drive(3'b100, 0, 0); cycle(1);
        chk("lock_addr0", s_addr, 32'h20004);
        drive(3'b100, 0, 0); cycle(1);
        drive(3'b101, 0, 0); cycle(1);
        chk("lock_addr2", s_addr, 32'h20004);
        chk("lock_nognt", s_gnt, 3'b000);
        drive(3'b101, 1, 0); cycle(1);
        chk("lock_gnt_h2", s_gnt, 3'b100);
        drive(3'b001, 1, 0); cycle(1);
        chk("lock_gnt_h0", s_gnt, 3'b001);
        drive('0, 0, 1); cycle(1);
        chk("lock_rv_h2", s_rvalid, 3'b100);
        drive('0, 0, 1); cycle(1);
        chk("lock_rv_h0", s_rvalid, 3'b001);
        drive('0, 0, 0); cycle(1);

        // Full back-pressure with no same-cycle pop bypass.
        drive(3'b001, 1, 0); cycle(1);
        chk("full_out1", s_out, 2'd0);
        drive(3'b001, 1, 0); cycle(1);
        chk("full_out2", s_out, 2'd1);
        drive(3'b001, 1, 0); cycle(1);
        chk("full_req3", s_dreq, 1'b0);
        chk("full_out3", s_out, 2'd2);
        drive(3'b001, 1, 0); cycle(1);
        chk("full_out4", s_out, 2'd2);
        drive(3'b001, 1, 1); cycle(1);
        chk("full_req5", s_dreq, 1'b0);
        chk("full_out5", s_out, 2'd2);
        drive(3'b001, 1, 0); cycle(1);
        chk("full_req6", s_dreq, 1'b1);
        chk("full_out6", s_out, 2'd1);
        drive('0, 0, 1); cycle(1);
        drive('0, 0, 1); cycle(1);
        drive('0, 0, 0); cycle(1);

        // Response routing and error flag.
        drive(3'b010, 1, 0); cycle(1);
        chk("route_gnt_h1", s_gnt, 3'b010);
        host_we[0] = 1'b1;
        drive(3'b001, 1, 0); cycle(1);
        chk("route_gnt_h0", s_gnt, 3'b001);
        chk("route_we", s_we, 1'b1);
        host_we[0] = 1'b0;
        drive('0, 0, 1); dev_rdata = 32'hDEADBEEF; dev_err = 0; cycle(1);
        chk("route_rv_h1", s_rvalid, 3'b010);
        chk("route_rdata", s_rdata, 32'hDEADBEEF);
        chk("route_err0", s_err, 3'b000);
        drive('0, 0, 1); dev_err = 1; cycle(1);
        chk("route_rv_h0", s_rvalid, 3'b001);
        chk("route_err1", s_err, 3'b001);
        dev_err = 0;
        drive('0, 0, 0); cycle(1);

        // Stray response.
        drive('0, 0, 1); cycle(1);
        chk("stray_rv", s_rvalid, 3'b000);
        drive('0, 0, 0); cycle(1);
        chk("stray_proto", s_proto, 1'b1);
        drive('0, 0, 0); cycle(1);
        chk("stray_sticky", s_proto, 1'b1);

        // Reset with two outstanding.
        drive(3'b001, 1, 0); cycle(1);
        drive(3'b001, 1, 0); cycle(1);
        drive('0, 0, 0); cycle(1);
        chk("pre_rst_out", s_out, 2'd2);
        do_reset();
        drive(3'b111, 1, 0); cycle(1);
        chk("post_rst_out", s_out, 2'd0);
        chk("post_rst_proto", s_proto, 1'b0);
        chk("post_rst_gnt", s_gnt, 3'b001);
        drive('0, 0, 1); cycle(1);
        drive('0, 0, 1); cycle(1);
        chk("post_rst_stray_rv", s_rvalid, 3'b000);
        drive('0, 0, 0); cycle(1);
        chk("post_rst_stray_proto", s_proto, 1'b1);
        do_reset();

        // Randomized traffic; hosts hold requests until granted.
        host_req = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int h = 0; h < N; h++) begin
                if (host_req[h] && s_gnt[h]) begin
                    host_req[h] = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_req(h);
                end else if (!host_req[h] && $urandom_range(0, 3) == 0) begin
                    new_req(h);
                end
            end
            dev_gnt = ($urandom_range(0, 3) != 0);
            dev_rvalid = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
            dev_err = 1'($urandom_range(0, 1));
            dev_rdata = $urandom;
            s_gnt = '0;
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Shares one device-side memory port (e.g. ram_1p or a bus device slot) between NrHosts requesters using the req/gnt/rvalid protocol of the Ibex instruction and data interfaces. Selection is round-robin, or fixed priority with index 0 highest. The selection is locked while the device stalls. Each accepted request's host index is queued so in-order responses route back to the correct host. Sits between core/testutil hosts and a single shared device in simulation tops and small SoCs.

Parameters:
NrHosts, 3, number of requesting hosts (>=2)
DataWidth, 32, data bus width in bits
AddressWidth, 32, address width in bits
MaxOutstanding, 2, depth of response-tag queue; max accepted-but-unanswered requests (>=1)
FixedPriority, 1'b0, 1: lowest host index always wins; 0: round-robin

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
host_req_i  in  NrHosts  per-host request, held until granted
host_gnt_o  out  NrHosts  per-host grant (one-hot or zero)
host_addr_i  in  NrHosts*AddressWidth  per-host address, packed, host 0 in LSBs
host_we_i  in  NrHosts  per-host write enable
host_be_i  in  NrHosts*DataWidth/8  per-host byte enables
host_wdata_i  in  NrHosts*DataWidth  per-host write data
host_rvalid_o  out  NrHosts  per-host response valid (one-hot or zero)
host_rdata_o  out  DataWidth  response data, broadcast to all hosts
host_err_o  out  NrHosts  per-host response error, qualified by host_rvalid_o
dev_req_o  out  1  device request
dev_gnt_i  in  1  device grant
dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  AW/1/DW/8/DW  muxed request fields
dev_rvalid_i  in  1  device response valid
dev_rdata_i  in  DataWidth  device response data
dev_err_i  in  1  device response error
outstanding_o  out  $clog2(MaxOutstanding+1)  current tag-queue occupancy
proto_err_o  out  1  sticky: dev_rvalid_i seen with empty tag queue

Behaviour:
- Reset (rst_i high at clk_i edge): prio_q=0, lock_q=0, tag queue empty, proto_err_o=0. Outputs settle to: host_gnt_o=0, host_rvalid_o=0, host_err_o=0, dev_req_o=0, outstanding_o=0. Reset mid-transfer discards outstanding tags; later stray responses set proto_err_o.
- Arbitration is combinational, no added latency.
  - Round-robin: sel = first index with host_req_i set, scanning from prio_q upward with wrap at NrHosts-1 -> 0.
  - FixedPriority=1: scan always starts at 0.
- Lock: if dev_req_o=1 and dev_gnt_i=0 at a clock edge, set lock_q=1 and locked_sel_q=sel. While lock_q=1, sel=locked_sel_q regardless of other requests. Clear lock_q on the accepting edge.
- dev_req_o = (any host_req_i | lock_q) & !full. dev_addr/we/be/wdata = fields of host sel. Fields are 0 when dev_req_o=0.
- Hosts must not drop req before gnt. If a locked host drops req anyway, dev_req_o stays high with its fields (protocol violation, undefined; no check).
- Accept = dev_req_o & dev_gnt_i.
  - host_gnt_o[sel]=1 that cycle.
  - sel is pushed into the tag queue.
  - Round-robin: prio_q <= (sel==NrHosts-1) ? 0 : sel+1.
- No accept: prio_q holds.
- Full: when occupancy==MaxOutstanding, dev_req_o=0. There is no same-cycle pop bypass, even if dev_rvalid_i is high.
- Response: when dev_rvalid_i=1 and queue non-empty:
  - host_rvalid_o[head]=1, host_err_o[head]=dev_err_i.
  - host_rdata_o = dev_rdata_i (passed through every cycle).
  - Head is popped.
- Empty queue: if dev_rvalid_i=1 with an empty queue, no host_rvalid_o; proto_err_o <= 1 until reset.
- Responses must arrive at least one cycle after their grant. A response in the grant cycle sees the pre-push queue.
- Simultaneous push and pop: occupancy unchanged; ordering preserved.
- outstanding_o = registered occupancy.

Decomposition:
- Shared package bus_arb_pkg: function for the round-robin next-pointer/wrap and the ceil-log2 width helper. No typedefs are needed beyond the host-index width localparam.
- One sub-module: bus_arb_tag_fifo, a synchronous FIFO.
  - Storage: $clog2(NrHosts) bits wide, MaxOutstanding deep.
  - Ports: push, pop, head, full, empty, count.
  - Same synchronous active-high reset.

Test Plan:
- RR fairness: NrHosts=3, all req held high, dev_gnt_i=1, rvalid 1 cycle after each grant -> grant order 0,1,2,0,1,2; outstanding_o never exceeds 1.
- Stall lock: host 2 requests, dev_gnt_i=0 for 3 cycles, host 0 raises req in cycle 2 -> dev_addr_o stays host 2 address (e.g. 0x20004); grant to host 2 first, then host 0.
- Full back-pressure: MaxOutstanding=2, grants accepted at cycles 1 and 2, no rvalid -> dev_req_o=0 from cycle 3. rvalid at cycle 5 -> dev_req_o high again at cycle 6; outstanding_o sequence 1,2,2,2,1.
- Response routing and err: host 1 read then host 0 write. Device returns rdata=0xDEADBEEF err=0, then err=1 -> host_rvalid_o=3'b010 with rdata 0xDEADBEEF, then 3'b001 with host_err_o[0]=1.
- Stray response: dev_rvalid_i pulse with queue empty -> no host_rvalid_o; proto_err_o=1 and stays set until rst_i.
- Reset mid-operation: rst_i asserted with 2 outstanding -> next cycle outstanding_o=0, all gnt/rvalid=0, prio_q=0 (host 0 wins next contention).
